demux_rr_dispatcher: RTL and testbench
======================================

Name: demux_rr_dispatcher

Overview:
- Sequencing controller for the 1-to-4 demux datapath.
- Accepts a single valid/ready input stream and distributes it to four output channels in bursts of BURST_LEN beats.
- Uses round-robin order over channels enabled in a mask.
- Drives the demux 2-bit select and a one-hot per-channel valid. Holds one registered beat toward the selected channel.

Parameters:
- DATA_W, 8, width of the data beat
- BURST_LEN, 4, beats sent to a channel before rotating (>=1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset
- en  input  1  dispatcher enable
- ch_mask  input  4  channel enable mask, bit i = channel i eligible
- in_valid  input  1  input beat valid
- in_data  input  DATA_W  input beat
- in_ready  output  1  input accept (combinational)
- out_ready  input  4  per-channel ready
- out_valid  output  4  one-hot per-channel valid, registered
- out_data  output  DATA_W  shared output data, registered
- sel  output  2  current demux select, registered
- busy  output  1  high when state != IDLE

Behaviour:
- Reset: sync active-low, sampled on clk rising edge when rst_n=0. Sets state=IDLE, sel=2'b11, out_valid=0, out_data=0, beat_cnt=0, busy=0. in_ready=0 follows from the state. A held beat present at reset is discarded.
- hold: internal flag, hold = |out_valid.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: hold & out_ready[sel]. out_ready bits other than sel are ignored.
- in_ready = (state==SEND) & (~hold | out_ready[sel]).
- Data path:
  - Input transfer in cycle t: out_data<=in_data and out_valid<=(1<<sel) at t+1. Latency is 1 cycle.
  - Output transfer without a simultaneous input transfer: out_valid<=0.
  - Simultaneous input and output transfer: the new beat replaces the held one, so out_valid stays asserted (back-to-back throughput of 1 beat/cycle).
  - out_data holds its last value while out_valid=0.
- Held beat rules: out_valid/out_data are stable while hold & ~out_ready[sel]. sel never changes while hold=1.
- States:
  - IDLE: if en & |ch_mask -> ARB.
  - ARB (1 cycle):
    - Picks the first channel with ch_mask set, searching sel+1, sel+2, sel+3, sel (mod 4).
    - Loads sel, clears beat_cnt, -> SEND.
    - If en=0 or ch_mask==0 -> IDLE, sel unchanged.
  - SEND:
    - On each input transfer, beat_cnt increments.
    - The transfer made with beat_cnt==BURST_LEN-1 clears beat_cnt and -> DRAIN.
    - en=0 with no input transfer that cycle -> DRAIN, ending the burst early.
  - DRAIN:
    - in_ready=0. Wait until ~hold, or an output transfer occurs that cycle.
    - Then -> ARB if en & |ch_mask, else IDLE.
- Mask/enable rules:
  - ch_mask is sampled only in IDLE, ARB and DRAIN exit. Changes during SEND do not affect the current burst; sel may stay on a channel whose mask bit has since dropped.
  - A channel masked off is never selected at ARB.
  - A single enabled channel is reselected every round.
- Reset from sel=3 makes the first pick channel 0, if enabled.
- Widths: beat_cnt is $clog2(BURST_LEN)+1 bits. No overflow is possible, because beat_cnt is cleared at BURST_LEN-1.
- Deadlock freedom: the block never waits on an unselected channel's ready.

Test Plan:
- Basic burst, BURST_LEN=4:
  - Stimulus: mask=4'b1111, en=1, all out_ready=1, 16 continuous beats 0x00..0x0F.
  - Response: beats 0-3 on ch0 (sel=0), 4-7 on ch1, 8-11 on ch2, 12-15 on ch3.
  - out_valid one-hot each beat.
  - Exactly 2 bubble cycles (DRAIN+ARB) between bursts.
- Mask skip:
  - Stimulus: mask=4'b1010, 8 beats.
  - Response: beats 0-3 on ch1, beats 4-7 on ch3. ch0 and ch2 never see out_valid.
- Backpressure:
  - Stimulus: ch0 out_ready=0 for 5 cycles mid-burst, holding beat 0x02.
  - Response: out_valid=4'b0001 and out_data=0x02 stable throughout; in_ready=0; sel=0.
  - On release, beat 0x03 follows next cycle with no loss or duplicate.
- Early stop:
  - Stimulus: en dropped after the 2nd beat of a burst.
  - Response: held beat delivered, then IDLE with busy=0.
  - Re-enable resumes at the next channel (sel+1).
- Mask change and empty mask:
  - Mask cleared to 0 during SEND: the current burst completes, then IDLE.
  - mask=0 with en=1 from reset: busy stays 0, in_ready stays 0.
- Reset mid-burst:
  - Stimulus: rst_n=0 for one cycle while hold=1 on ch2.
  - Response: next cycle out_valid=0, sel=3, in_ready=0.
  - The next burst starts on ch0.

Source files
------------

// File: rtl/demux_rr_dispatcher.sv
// -----------------------------------------------------------------------------
// demux_rr_dispatcher
//
// Sequencing controller for a 1-to-4 demux datapath. A single valid/ready input
// stream is split into bursts of BURST_LEN beats. Each burst goes to one output
// channel. Channels are visited in round-robin order, restricted to those
// enabled in ch_mask. One registered beat is held toward the selected channel.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         dispatcher enable; dropping it ends the current burst early
//   ch_mask    per-channel eligibility, bit i = channel i
//   in_valid   input beat valid
//   in_data    input beat
//   in_ready   input accept (combinational)
//   out_ready  per-channel ready; only the selected channel's bit is used
//   out_valid  one-hot per-channel valid (registered)
//   out_data   shared output data (registered)
//   sel        demux select (registered)
//   busy       controller is not idle
// -----------------------------------------------------------------------------
module demux_rr_dispatcher #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        ch_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [3:0]        out_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic hold;
  logic sel_ready;
  logic out_xfer;
  logic in_xfer;
  logic can_arb;

  // Round-robin pick: the first enabled channel searching cur+1, cur+2,
  // cur+3, cur. Iterating from the farthest candidate down lets the nearest
  // one overwrite the result. Callers guarantee mask is non-zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] cur,
                                         input logic [3:0] mask);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = cur;
    for (int i = 4; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (mask[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign hold      = |out_valid_q;
  assign sel_ready = out_ready[sel_q];
  assign out_xfer  = hold & sel_ready;
  assign in_ready  = (state_q == SEND) & (~hold | sel_ready);
  assign in_xfer   = in_valid & in_ready;
  assign can_arb   = en & (|ch_mask);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // A new beat replaces the held one (which leaves in the same cycle when
    // both transfer), so the valid stays up for back-to-back streaming.
    if (in_xfer) begin
      out_valid_d = 4'b0001 << sel_q;
      out_data_d  = in_data;
    end else if (out_xfer) begin
      out_valid_d = 4'b0000;
    end

    case (state_q)
      IDLE: begin
        if (can_arb) state_d = ARB;
      end
      ARB: begin
        if (can_arb) begin
          sel_d      = rr_pick(sel_q, ch_mask);
          beat_cnt_d = '0;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (in_xfer) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (!en) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // sel must not move while a beat is still held for the channel.
        if (!hold || out_xfer) state_d = can_arb ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'b11;
      out_valid_q <= 4'b0000;
      out_data_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
module tb_demux_rr_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] ch_mask;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] out_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       busy;

  int tests = 0;
  int fails = 0;

  demux_rr_dispatcher #(.DATA_W(8), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ch_mask   (ch_mask),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Output-transfer recorder
  int         cyc = 0;
  int         n_rec = 0;
  logic [7:0] rec_data [64];
  logic [1:0] rec_sel  [64];
  logic [3:0] rec_ov   [64];
  int         rec_cyc  [64];
  logic [3:0] seen_valid = 4'b0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && ((out_valid & out_ready) != 4'b0000) && n_rec < 64) begin
      rec_data[n_rec] <= out_data;
      rec_sel[n_rec]  <= sel;
      rec_ov[n_rec]   <= out_valid;
      rec_cyc[n_rec]  <= cyc;
      n_rec           <= n_rec + 1;
    end
    if (!rst_n) seen_valid <= 4'b0000;
    else        seen_valid <= seen_valid | out_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] next_data;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick(1);
    rst_n    = 1'b1;
  endtask

  // Streams n beats from next_data upward, bounded by a cycle budget.
  task automatic send(input int n, input string tag);
    int  k;
    int  budget;
    logic acc;
    k = 0;
    budget = 0;
    in_valid = 1'b1;
    in_data  = next_data;
    while (k < n && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
      if (acc) begin
        k++;
        next_data = next_data + 8'd1;
        in_data   = next_data;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_beats_accepted"}, k, n);
  endtask

  int base;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    ch_mask   = 4'b0000;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 4'b0000;
    next_data = 8'h00;

    // Reset state
    tick(2);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_sel", sel, 2'b11);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", out_data, 8'h00);

    // Basic burst: 16 beats over all four channels
    rst_n = 1'b1; en = 1'b1; ch_mask = 4'b1111; out_ready = 4'b1111;
    base = n_rec; next_data = 8'h00;
    send(16, "basic");
    tick(2);
    chk("basic_count", n_rec - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("basic_data%0d", i), rec_data[base+i], i);
      chk($sformatf("basic_sel%0d", i), rec_sel[base+i], i / 4);
      chk($sformatf("basic_onehot%0d", i), rec_ov[base+i], 4'b0001 << (i / 4));
      if (i > 0)
        chk($sformatf("basic_gap%0d", i), rec_cyc[base+i] - rec_cyc[base+i-1],
            (i % 4 == 0) ? 3 : 1);
    end

    // Mask skip: only channels 1 and 3
    do_reset();
    ch_mask = 4'b1010; base = n_rec; next_data = 8'h00;
    send(8, "mask");
    tick(2);
    chk("mask_count", n_rec - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mask_sel%0d", i), rec_sel[base+i], (i < 4) ? 1 : 3);
      chk($sformatf("mask_data%0d", i), rec_data[base+i], i);
    end
    chk("mask_seen_valid", seen_valid, 4'b1010);

    // Backpressure on channel 0 while 0x02 is held
    do_reset();
    ch_mask = 4'b1111; base = n_rec; next_data = 8'h00;
    send(3, "bp");
    out_ready = 4'b1110; in_valid = 1'b1; in_data = 8'h03;
    #1;
    chk("bp_in_ready_blocked", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("bp_hold_valid%0d", i), out_valid, 4'b0001);
      chk($sformatf("bp_hold_data%0d", i), out_data, 8'h02);
      chk($sformatf("bp_hold_ready%0d", i), in_ready, 1'b0);
      chk($sformatf("bp_hold_sel%0d", i), sel, 2'd0);
    end
    out_ready = 4'b1111;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick(1);
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 4'b0001);
    chk("bp_next_data", out_data, 8'h03);
    tick(2);
    chk("bp_count", n_rec - base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_data%0d", i), rec_data[base+i], i);

    // Early stop after the second beat, with the held beat stalled
    do_reset();
    ch_mask = 4'b1111; base = n_rec; next_data = 8'h00;
    send(2, "stop");
    en = 1'b0; out_ready = 4'b0000;
    tick(1);
    chk("stop_drain_busy", busy, 1'b1);
    chk("stop_drain_valid", out_valid, 4'b0001);
    chk("stop_drain_data", out_data, 8'h01);
    tick(1);
    chk("stop_wait_busy", busy, 1'b1);
    out_ready = 4'b1111;
    tick(1);
    chk("stop_idle_busy", busy, 1'b0);
    chk("stop_idle_valid", out_valid, 4'b0000);
    chk("stop_idle_ready", in_ready, 1'b0);
    chk("stop_count", n_rec - base, 2);
    en = 1'b1;
    tick(2);
    chk("stop_resume_sel", sel, 2'd1);
    chk("stop_resume_busy", busy, 1'b1);
    chk("stop_resume_ready", in_ready, 1'b1);

    // Mask cleared mid-burst: burst completes, then idle
    do_reset();
    ch_mask = 4'b1111; base = n_rec; next_data = 8'h00;
    send(2, "mclr_a");
    ch_mask = 4'b0000;
    send(2, "mclr_b");
    chk("mclr_drain_busy", busy, 1'b1);
    tick(1);
    chk("mclr_idle_busy", busy, 1'b0);
    tick(3);
    chk("mclr_still_idle", busy, 1'b0);
    chk("mclr_count", n_rec - base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mclr_sel%0d", i), rec_sel[base+i], 2'd0);

    // Empty mask from reset
    rst_n = 1'b0; ch_mask = 4'b0000; en = 1'b1;
    tick(1);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("empty_busy%0d", i), busy, 1'b0);
      chk($sformatf("empty_ready%0d", i), in_ready, 1'b0);
    end
    in_valid = 1'b0;

    // Single channel reselected, then reset while holding on ch2
    do_reset();
    ch_mask = 4'b0100; out_ready = 4'b1111; base = n_rec; next_data = 8'h00;
    send(5, "rmid");
    out_ready = 4'b0000;
    chk("rmid_count", n_rec - base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rmid_sel%0d", i), rec_sel[base+i], 2'd2);
    chk("rmid_hold_valid", out_valid, 4'b0100);
    chk("rmid_hold_data", out_data, 8'h04);
    rst_n = 1'b0; in_valid = 1'b1;
    tick(1);
    chk("rmid_rst_valid", out_valid, 4'b0000);
    chk("rmid_rst_sel", sel, 2'b11);
    chk("rmid_rst_ready", in_ready, 1'b0);
    chk("rmid_rst_busy", busy, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0; ch_mask = 4'b1111; out_ready = 4'b1111;
    tick(2);
    chk("rmid_next_sel", sel, 2'd0);
    chk("rmid_next_busy", busy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
